// File: rtl/mips_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mips_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = 32;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle unsigned shift-add multiply / restoring divide on a {hi,lo} accumulator.
// load_i seeds lo with a_i and hi with 0; after 32 steps {hi,lo} holds product or {rem,quo}.
module mdu_iter_core
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 is_div_i,
    input  logic [MDU_WIDTH-1:0] a_i,
    input  logic [MDU_WIDTH-1:0] b_i,
    output logic [MDU_WIDTH-1:0] hi_o,
    output logic [MDU_WIDTH-1:0] lo_o
);

    logic [MDU_WIDTH-1:0] hi_q, hi_d;
    logic [MDU_WIDTH-1:0] lo_q, lo_d;
    logic [MDU_WIDTH-1:0] b_q,  b_d;
    logic                 div_q, div_d;

    logic [MDU_WIDTH:0]   add_sum;
    logic [MDU_WIDTH:0]   mul_sel;
    logic [MDU_WIDTH:0]   shl;
    logic [MDU_WIDTH-1:0] diff;

    assign add_sum = {1'b0, hi_q} + {1'b0, b_q};
    assign mul_sel = lo_q[0] ? add_sum : {1'b0, hi_q};
    assign shl     = {hi_q, lo_q[MDU_WIDTH-1]};
    assign diff    = shl[MDU_WIDTH-1:0] - b_q;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        div_d = div_q;
        if (load_i) begin
            hi_d  = '0;
            lo_d  = a_i;
            b_d   = b_i;
            div_d = is_div_i;
        end else if (step_i) begin
            if (div_q) begin
                // Restoring step: keep the partial remainder only when the trial subtract fits.
                if (shl >= {1'b0, b_q}) begin
                    hi_d = diff;
                    lo_d = {lo_q[MDU_WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shl[MDU_WIDTH-1:0];
                    lo_d = {lo_q[MDU_WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = mul_sel[MDU_WIDTH:1];
                lo_d = {mul_sel[0], lo_q[MDU_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            div_q <= div_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mdu.sv
// MIPS HI/LO multiply/divide unit: 33-cycle iterative ops (32 CALC + FIX), MTHI/MTLO in one edge.
// Starts while busy are dropped and raise hold; MDU_FAST_MUL_EN makes MULT/MULTU single-cycle.
module mdu
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [MDU_WIDTH-1:0] rs_data,
    input  logic [MDU_WIDTH-1:0] rt_data,
    input  logic                 rd_req,
    input  logic                 rd_sel,
    output logic [MDU_WIDTH-1:0] rd_data,
    output logic                 busy,
    output logic                 hold,
    output logic                 done
);

    mdu_state_t           state_q, state_d;
    logic [4:0]           count_q, count_d;
    logic [MDU_WIDTH-1:0] hi_q, hi_d;
    logic [MDU_WIDTH-1:0] lo_q, lo_d;
    logic                 div_q, div_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic [MDU_WIDTH-1:0] dvd_q, dvd_d;

    mdu_op_t              op_e;
    logic                 accept;
    logic                 is_mul;
    logic                 is_div;
    logic                 is_iter;
    logic                 is_signed;
    logic                 rs_neg;
    logic                 rt_neg;
    logic [MDU_WIDTH-1:0] abs_rs;
    logic [MDU_WIDTH-1:0] abs_rt;
    logic [MDU_WIDTH-1:0] core_hi;
    logic [MDU_WIDTH-1:0] core_lo;
    logic [2*MDU_WIDTH-1:0] prod;
    logic [2*MDU_WIDTH-1:0] prod_s;
    logic [MDU_WIDTH-1:0] quo;
    logic [MDU_WIDTH-1:0] rem;

    assign op_e      = mdu_op_t'(op);
    assign accept    = (state_q == ST_IDLE) && start;
    assign is_mul    = (op_e == MDU_MULT) || (op_e == MDU_MULTU);
    assign is_div    = (op_e == MDU_DIV)  || (op_e == MDU_DIVU);
    assign is_signed = (op_e == MDU_MULT) || (op_e == MDU_DIV);
    assign rs_neg    = is_signed && rs_data[MDU_WIDTH-1];
    assign rt_neg    = is_signed && rt_data[MDU_WIDTH-1];
    assign abs_rs    = rs_neg ? (~rs_data + 1'b1) : rs_data;
    assign abs_rt    = rt_neg ? (~rt_data + 1'b1) : rt_data;

`ifdef MDU_FAST_MUL_EN
    assign is_iter = is_div;

    logic [2*MDU_WIDTH-1:0] fast_a;
    logic [2*MDU_WIDTH-1:0] fast_b;
    logic [2*MDU_WIDTH-1:0] fast_prod;

    // Sign/zero extension to 64 bits makes the low 64 bits of one product correct for both.
    assign fast_a    = {{MDU_WIDTH{rs_neg}}, rs_data};
    assign fast_b    = {{MDU_WIDTH{rt_neg}}, rt_data};
    assign fast_prod = fast_a * fast_b;
`else
    assign is_iter = is_mul || is_div;
`endif

    mdu_iter_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept && is_iter),
        .step_i   (state_q == ST_CALC),
        .is_div_i (is_div),
        .a_i      (abs_rs),
        .b_i      (abs_rt),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            dvd_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            dvd_q   <= dvd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = '0;
        case (state_q)
            ST_IDLE: if (accept && is_iter) state_d = ST_CALC;
            ST_CALC: begin
                count_d = count_q + 5'd1;
                if (count_q == 5'(MDU_ITER - 1)) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_FIX);
        hold = busy && (rd_req || start);
    end

    always_comb begin
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        dvd_d  = dvd_q;
        if (accept && is_iter) begin
            div_d  = is_div;
            neg_d  = rs_neg ^ rt_neg;
            rneg_d = rs_neg;
            dz_d   = is_div && (rt_data == '0);
            dvd_d  = rs_data;
        end
    end

    assign prod   = {core_hi, core_lo};
    assign prod_s = neg_q ? (~prod + 1'b1) : prod;

    always_comb begin
        quo = neg_q  ? (~core_lo + 1'b1) : core_lo;
        rem = rneg_q ? (~core_hi + 1'b1) : core_hi;
        if (dz_q) begin
            quo = '1;
            rem = dvd_q;
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == ST_FIX) begin
            if (div_q) begin
                hi_d = rem;
                lo_d = quo;
            end else begin
                {hi_d, lo_d} = prod_s;
            end
        end else if (accept) begin
            case (op_e)
                MDU_MTHI: hi_d = rs_data;
                MDU_MTLO: lo_d = rs_data;
`ifdef MDU_FAST_MUL_EN
                MDU_MULT, MDU_MULTU: {hi_d, lo_d} = fast_prod;
`endif
                default: ;
            endcase
        end
    end

    assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu: latency, signed/unsigned results, divide corner cases, hold and reset.
module tb_mdu;
    import mips_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        hold;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .rd_req  (rd_req),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .busy    (busy),
        .hold    (hold),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic read_hl(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        rd_req = 1'b1;
        rd_sel = 1'b0;
        #1;
        check({tag, ".lo"}, rd_data, elo);
        rd_sel = 1'b1;
        #1;
        check({tag, ".hi"}, rd_data, ehi);
        rd_req = 1'b0;
        rd_sel = 1'b0;
    endtask

    // Drives start for one cycle from the current point; returns #1 after the sampling edge.
    task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = MDU_NONE;
    endtask

    task automatic run_op(input string tag, input mdu_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input bit iter,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        int dn;
        issue(o, a, b);
        cyc = 0;
        dn  = 0;
        while (busy && cyc < 60) begin
            if (done) dn++;
            cyc++;
            @(posedge clk);
            #1;
        end
        check({tag, ".busy_cycles"}, 32'(cyc), iter ? 32'd33 : 32'd0);
        check({tag, ".done_pulses"}, 32'(dn),  iter ? 32'd1  : 32'd0);
        read_hl(tag, ehi, elo);
    endtask

    initial begin
        int hold_miss;
        int done_seen;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = MDU_NONE;
        rs_data = '0;
        rt_data = '0;
        rd_req  = 1'b0;
        rd_sel  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.hold", 32'(hold), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        read_hl("rst", 32'h0, 32'h0);

        @(posedge clk);
        #1;
        run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, !FAST, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg",  MDU_MULT,  32'hFFFFFFFD, 32'd7,        !FAST, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("mult_6x7",  MDU_MULT,  32'd6,        32'd7,        !FAST, 32'h0,        32'd42);
        run_op("divu_100_7", MDU_DIVU, 32'd100,      32'd7,        1'b1,  32'd2,        32'd14);
        run_op("div_m7_2",  MDU_DIV,   32'hFFFFFFF9, 32'd2,        1'b1,  32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf",   MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b1,  32'h0,        32'h80000000);
        run_op("div_5_0",   MDU_DIV,   32'd5,        32'd0,        1'b1,  32'd5,        32'hFFFFFFFF);
        run_op("div_m5_0",  MDU_DIV,   32'hFFFFFFFB, 32'd0,        1'b1,  32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("divu_3_9",  MDU_DIVU,  32'd3,        32'd9,        1'b1,  32'd3,        32'd0);

        // Read request plus a competing MTLO start for the whole busy window.
        issue(MDU_DIVU, 32'd100, 32'd7);
        hold_miss = 0;
        done_seen = 0;
        for (int i = 0; i < 33; i++) begin
            rd_req  = 1'b1;
            start   = (i < 32);
            op      = MDU_MTLO;
            rs_data = 32'hDEAD;
            #3;
            if (!(busy && hold)) hold_miss++;
            if (done) done_seen = i;
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        op     = MDU_NONE;
        rd_req = 1'b0;
        check("hold.missed_cycles", 32'(hold_miss), 32'd0);
        check("hold.done_cycle",    32'(done_seen), 32'd32);
        check("hold.busy_after",    32'(busy),      32'd0);
        read_hl("hold", 32'd2, 32'd14);

        // MTHI then read on the following cycle; MTLO must not disturb HI.
        issue(MDU_MTHI, 32'h00001234, 32'h0);
        rd_req = 1'b1;
        rd_sel = 1'b1;
        #1;
        check("mthi.rd_data", rd_data, 32'h00001234);
        check("mthi.hold",    32'(hold), 32'd0);
        check("mthi.busy",    32'(busy), 32'd0);
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        issue(MDU_MTLO, 32'h0000ABCD, 32'h0);
        read_hl("mtlo", 32'h00001234, 32'h0000ABCD);

        // NONE op must leave everything untouched.
        issue(MDU_NONE, 32'h55555555, 32'h1);
        check("none.busy", 32'(busy), 32'd0);
        read_hl("none", 32'h00001234, 32'h0000ABCD);

        // Reset in the middle of CALC aborts without writing HI/LO.
        issue(MDU_DIVU, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        check("abort.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        read_hl("abort", 32'h0, 32'h0);
        repeat (40) @(posedge clk);
        #1;
        check("abort.busy_late", 32'(busy), 32'd0);
        read_hl("abort_late", 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
